// File: rtl/snake_engine.sv
// Snake game core: segment store, step timer, steering, growth, collisions and pixel classification.
// Optional macro SNAKE_WRAP_EN: the head wraps to the opposite playable edge instead of hitting walls.
module snake_engine #(
  parameter int GRID_W     = 40,
  parameter int GRID_H     = 30,
  parameter int MAX_LEN    = 32,
  parameter int INIT_LEN   = 3,
  parameter int STEP_TICKS = 12_500_000
) (
  input  logic       Clk_50mhz,
  input  logic       Rst,
  input  logic [3:0] Key_dir,
  input  logic [2:0] Game_status,
  input  logic       Body_add_sig,
  input  logic       Flash_sig,
  input  logic [9:0] Pixel_x,
  input  logic [9:0] Pixel_y,
  output logic [1:0] Object,
  output logic [5:0] Head_x,
  output logic [5:0] Head_y,
  output logic [6:0] Body_len,
  output logic       Hit_wall_sig,
  output logic       Hit_body_sig,
  output logic       Step_pulse
);

  localparam int TW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(STEP_TICKS - 1);
  localparam logic [5:0] X_MAX = 6'(GRID_W - 2);
  localparam logic [5:0] Y_MAX = 6'(GRID_H - 2);
  localparam logic [5:0] X_EDGE = 6'(GRID_W - 1);
  localparam logic [5:0] Y_EDGE = 6'(GRID_H - 1);
  localparam logic [6:0] LEN_MAX = 7'(MAX_LEN);
  localparam logic [6:0] LEN_INIT = 7'(INIT_LEN);
  localparam logic [2:0] ST_START = 3'b001, ST_PLAY = 3'b010, ST_END = 3'b100;
  localparam logic [1:0] OBJ_NONE = 2'b00, OBJ_HEAD = 2'b01, OBJ_BODY = 2'b10, OBJ_WALL = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;
  typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;

  state_t        state, nxt;
  dir_t          dir, pend_dir, key_d, step_dir;
  logic          pend_vld, key_ok, grow_pend, add_q, add_rise;
  logic [TW-1:0] tick;
  logic [5:0]    seg_x [MAX_LEN];
  logic [5:0]    seg_y [MAX_LEN];
  logic [5:0]    raw_x, raw_y, nx, ny, cx, cy;
  logic          wall_hit, body_hit, hit;
  logic [1:0]    obj_nxt;

  assign Head_x     = seg_x[0];
  assign Head_y     = seg_y[0];
  assign Step_pulse = (state == RUN) && (tick == TICK_MAX);
  assign add_rise   = Body_add_sig && !add_q;
  assign step_dir   = pend_vld ? pend_dir : dir;
  assign hit        = Step_pulse && (wall_hit || body_hit);

  // Directions are encoded so that flipping bit 0 gives the opposite.
  always_comb begin
    key_d = RIGHT;
    if (Key_dir[3])      key_d = UP;
    else if (Key_dir[2]) key_d = DOWN;
    else if (Key_dir[1]) key_d = LEFT;
    key_ok = (|Key_dir) && (key_d != dir_t'(dir ^ 2'd1));
  end

  always_comb begin
    raw_x = seg_x[0];
    raw_y = seg_y[0];
    case (step_dir)
      UP:      raw_y = seg_y[0] - 6'd1;
      DOWN:    raw_y = seg_y[0] + 6'd1;
      LEFT:    raw_x = seg_x[0] - 6'd1;
      default: raw_x = seg_x[0] + 6'd1;
    endcase
    nx = raw_x;
    ny = raw_y;
`ifdef SNAKE_WRAP_EN
    wall_hit = 1'b0;
    if (raw_x == 6'd0)        nx = X_MAX;
    else if (raw_x == X_EDGE) nx = 6'd1;
    if (raw_y == 6'd0)        ny = Y_MAX;
    else if (raw_y == Y_EDGE) ny = 6'd1;
`else
    wall_hit = (raw_x < 6'd1) || (raw_x > X_MAX) || (raw_y < 6'd1) || (raw_y > Y_MAX);
`endif
    // The tail vacates on a plain move, so it only blocks when growing.
    body_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++)
      if ((i <= int'(Body_len) - 2 || (grow_pend && i == int'(Body_len) - 1)) &&
          seg_x[i] == nx && seg_y[i] == ny)
        body_hit = 1'b1;
  end

  always_comb begin
    nxt = state;
    if (Game_status == ST_START || Game_status == ST_END) nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (Game_status == ST_PLAY) nxt = RUN;
        RUN:     if (hit) nxt = DEAD;
        default: nxt = state;
      endcase
    end
  end

  always_comb begin
    cx = Pixel_x[9:4];
    cy = Pixel_y[9:4];
    obj_nxt = OBJ_NONE;
    if (Pixel_x >= 10'd640 || Pixel_y >= 10'd480) obj_nxt = OBJ_NONE;
    else if (cx == 6'd0 || cx == X_EDGE || cy == 6'd0 || cy == Y_EDGE) obj_nxt = OBJ_WALL;
    else if (Flash_sig && cx == seg_x[0] && cy == seg_y[0]) obj_nxt = OBJ_HEAD;
    else if (Flash_sig) begin
      for (int i = 1; i < MAX_LEN; i++)
        if (i < int'(Body_len) && cx == seg_x[i] && cy == seg_y[i]) obj_nxt = OBJ_BODY;
    end
  end

  always_ff @(posedge Clk_50mhz) begin
    if (Rst) begin
      state  <= IDLE;
      Object <= OBJ_NONE;
      add_q  <= 1'b0;
    end else begin
      state  <= nxt;
      Object <= obj_nxt;
      add_q  <= Body_add_sig;
    end
  end

  // Reset and every cycle spent in IDLE restore the starting snake.
  always_ff @(posedge Clk_50mhz) begin
    if (Rst || nxt == IDLE) begin
      dir          <= RIGHT;
      pend_dir     <= RIGHT;
      pend_vld     <= 1'b0;
      grow_pend    <= 1'b0;
      tick         <= '0;
      Body_len     <= LEN_INIT;
      Hit_wall_sig <= 1'b0;
      Hit_body_sig <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= (i < INIT_LEN) ? 6'(10 - i) : 6'd0;
        seg_y[i] <= (i < INIT_LEN) ? 6'd5 : 6'd0;
      end
    end else begin
      if (state == RUN) tick <= Step_pulse ? '0 : tick + 1'b1;
      else              tick <= '0;
      if (Step_pulse) begin
        pend_vld  <= 1'b0;
        grow_pend <= 1'b0;
        dir       <= step_dir;
        if (wall_hit)      Hit_wall_sig <= 1'b1;
        else if (body_hit) Hit_body_sig <= 1'b1;
        else begin
          for (int i = 1; i < MAX_LEN; i++) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
          seg_x[0] <= nx;
          seg_y[0] <= ny;
          if (grow_pend && Body_len < LEN_MAX) Body_len <= Body_len + 7'd1;
        end
      end else if (state == RUN && key_ok) begin
        pend_vld <= 1'b1;
        pend_dir <= key_d;
      end
      // A new grow request landing on a step edge survives to the next step.
      if (add_rise && Body_len < LEN_MAX) grow_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine with STEP_TICKS=4 and MAX_LEN=5 so every scenario fits in a few hundred cycles.
module tb_snake_engine;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_dir;
  logic [2:0] status;
  logic       body_add, flash;
  logic [9:0] pix_x, pix_y;
  logic [1:0] object;
  logic [5:0] head_x, head_y;
  logic [6:0] body_len;
  logic       hit_wall, hit_body, step;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  snake_engine #(.GRID_W(40), .GRID_H(30), .MAX_LEN(5), .INIT_LEN(3), .STEP_TICKS(4)) dut (
    .Clk_50mhz(clk), .Rst(rst), .Key_dir(key_dir), .Game_status(status),
    .Body_add_sig(body_add), .Flash_sig(flash), .Pixel_x(pix_x), .Pixel_y(pix_y),
    .Object(object), .Head_x(head_x), .Head_y(head_y), .Body_len(body_len),
    .Hit_wall_sig(hit_wall), .Hit_body_sig(hit_body), .Step_pulse(step)
  );

  task automatic tk();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of cycles until Step_pulse is seen (0 if already high).
  task automatic wait_step(output int n);
    n = 0;
    while (!step && n < 20) begin
      tk();
      n++;
    end
    if (!step) begin
      total++; bad++;
      $display("FAIL step_timeout got=no pulse in %0d cycles exp=pulse", n);
    end
  endtask

  task automatic do_step();
    int n;
    wait_step(n);
    tk();
  endtask

  task automatic test_reset();
    rst = 1'b1; status = 3'b001; key_dir = 4'd0; body_add = 1'b0; flash = 1'b0;
    pix_x = 10'd0; pix_y = 10'd0;
    tk(); tk();
    rst = 1'b0;
    total++; if (head_x !== 6'd10) begin bad++; $display("FAIL reset_head_x got=%0d exp=10", head_x); end
    total++; if (head_y !== 6'd5) begin bad++; $display("FAIL reset_head_y got=%0d exp=5", head_y); end
    total++; if (body_len !== 7'd3) begin bad++; $display("FAIL reset_len got=%0d exp=3", body_len); end
    total++; if ({hit_wall, hit_body, step} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {hit_wall, hit_body, step}); end
    total++; if (object !== 2'b00) begin bad++; $display("FAIL reset_object got=%b exp=00", object); end
  endtask

  task automatic test_object();
    flash = 1'b1;
    pix_x = 10'd160; pix_y = 10'd80; tk();
    total++; if (object !== 2'b01) begin bad++; $display("FAIL obj_head got=%b exp=01", object); end
    pix_x = 10'd128; tk();
    total++; if (object !== 2'b10) begin bad++; $display("FAIL obj_body got=%b exp=10", object); end
    pix_x = 10'd0; pix_y = 10'd0; tk();
    total++; if (object !== 2'b11) begin bad++; $display("FAIL obj_wall got=%b exp=11", object); end
    pix_x = 10'd639; pix_y = 10'd240; tk();
    total++; if (object !== 2'b11) begin bad++; $display("FAIL obj_right_wall got=%b exp=11", object); end
    pix_x = 10'd640; pix_y = 10'd80; tk();
    total++; if (object !== 2'b00) begin bad++; $display("FAIL obj_offscreen got=%b exp=00", object); end
    pix_x = 10'd200; pix_y = 10'd200; tk();
    total++; if (object !== 2'b00) begin bad++; $display("FAIL obj_empty got=%b exp=00", object); end
    flash = 1'b0; pix_x = 10'd160; pix_y = 10'd80; tk();
    total++; if (object !== 2'b00) begin bad++; $display("FAIL obj_flash_off got=%b exp=00", object); end
    flash = 1'b1; pix_x = 10'd176; pix_y = 10'd80;
  endtask

  task automatic test_step();
    int n;
    status = 3'b010;
    wait_step(n);
    total++; if (n !== 4) begin bad++; $display("FAIL step_first_latency got=%0d exp=4", n); end
    total++; if (head_x !== 6'd10) begin bad++; $display("FAIL step_pre_move got=%0d exp=10", head_x); end
    tk();
    total++; if (head_x !== 6'd11 || step !== 1'b0) begin bad++; $display("FAIL step_move1 got=%0d/%b exp=11/0", head_x, step); end
    wait_step(n);
    total++; if (n !== 3) begin bad++; $display("FAIL step_period got=%0d exp=3", n); end
    total++; if (object !== 2'b01) begin bad++; $display("FAIL step_obj_head got=%b exp=01", object); end
    tk();
    total++; if (head_x !== 6'd12 || head_y !== 6'd5 || body_len !== 7'd3) begin
      bad++; $display("FAIL step_move2 got=(%0d,%0d) len=%0d exp=(12,5) len=3", head_x, head_y, body_len); end
  endtask

  task automatic test_grow();
    body_add = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tk();
      if (i == 2) begin
        total++; if (body_len !== 7'd3 || step !== 1'b1) begin bad++; $display("FAIL grow_before_step got=%0d/%b exp=3/1", body_len, step); end
      end
    end
    total++; if (body_len !== 7'd4 || head_x !== 6'd14) begin bad++; $display("FAIL grow_once got=%0d x=%0d exp=4 x=14", body_len, head_x); end
    body_add = 1'b0; tk();
    do_step();
    body_add = 1'b1; tk(); body_add = 1'b0;
    do_step();
    total++; if (body_len !== 7'd5 || head_x !== 6'd16) begin bad++; $display("FAIL grow_to_max got=%0d x=%0d exp=5 x=16", body_len, head_x); end
    body_add = 1'b1; tk(); body_add = 1'b0;
    do_step();
    total++; if (body_len !== 7'd5 || head_x !== 6'd17) begin bad++; $display("FAIL grow_at_max got=%0d x=%0d exp=5 x=17", body_len, head_x); end
  endtask

  task automatic test_turn();
    key_dir = 4'b0010; tk(); key_dir = 4'd0;
    do_step();
    total++; if (head_x !== 6'd18 || head_y !== 6'd5) begin bad++; $display("FAIL turn_reverse got=(%0d,%0d) exp=(18,5)", head_x, head_y); end
    key_dir = 4'b0010; tk(); key_dir = 4'b1000; tk(); key_dir = 4'd0;
    do_step();
    total++; if (head_x !== 6'd18 || head_y !== 6'd4) begin bad++; $display("FAIL turn_up got=(%0d,%0d) exp=(18,4)", head_x, head_y); end
  endtask

  task automatic test_body_hit();
    int pulses = 0;
    key_dir = 4'b0010; tk(); key_dir = 4'd0;
    do_step();
    total++; if (head_x !== 6'd17 || head_y !== 6'd4) begin bad++; $display("FAIL bhit_left got=(%0d,%0d) exp=(17,4)", head_x, head_y); end
    key_dir = 4'b0100; tk(); key_dir = 4'd0;
    do_step();
    total++; if (hit_body !== 1'b1 || hit_wall !== 1'b0) begin bad++; $display("FAIL bhit_flags got=%b%b exp=01", hit_wall, hit_body); end
    for (int i = 0; i < 10; i++) begin tk(); if (step) pulses++; end
    total++; if (pulses !== 0) begin bad++; $display("FAIL bhit_dead_pulses got=%0d exp=0", pulses); end
    total++; if (head_x !== 6'd17 || head_y !== 6'd4 || body_len !== 7'd5) begin
      bad++; $display("FAIL bhit_frozen got=(%0d,%0d) len=%0d exp=(17,4) len=5", head_x, head_y, body_len); end
    status = 3'b100; tk();
    total++; if ({hit_wall, hit_body} !== 2'b00 || head_x !== 6'd10 || head_y !== 6'd5 || body_len !== 7'd3) begin
      bad++; $display("FAIL bhit_end_reinit got=%b%b (%0d,%0d) len=%0d exp=00 (10,5) len=3", hit_wall, hit_body, head_x, head_y, body_len); end
  endtask

  task automatic test_wall();
    int pulses = 0;
    status = 3'b010;
    repeat (28) do_step();
    total++; if (head_x !== 6'd38 || head_y !== 6'd5) begin bad++; $display("FAIL wall_approach got=(%0d,%0d) exp=(38,5)", head_x, head_y); end
    do_step();
`ifdef SNAKE_WRAP_EN
    total++; if (head_x !== 6'd1 || hit_wall !== 1'b0) begin bad++; $display("FAIL wall_wrap got=x%0d hit%b exp=x1 hit0", head_x, hit_wall); end
`else
    total++; if (hit_wall !== 1'b1 || head_x !== 6'd38 || hit_body !== 1'b0) begin
      bad++; $display("FAIL wall_hit got=hit%b%b x%0d exp=hit10 x38", hit_wall, hit_body, head_x); end
    for (int i = 0; i < 10; i++) begin tk(); if (step) pulses++; end
    total++; if (pulses !== 0) begin bad++; $display("FAIL wall_dead_pulses got=%0d exp=0", pulses); end
`endif
    status = 3'b001; tk();
  endtask

  task automatic test_rst_mid_run();
    int n;
    status = 3'b010;
    do_step(); do_step();
    total++; if (head_x !== 6'd12) begin bad++; $display("FAIL rst_pre got=%0d exp=12", head_x); end
    pix_x = 10'd0; pix_y = 10'd0;
    wait_step(n);
    rst = 1'b1; tk(); rst = 1'b0;
    total++; if (head_x !== 6'd10 || head_y !== 6'd5 || body_len !== 7'd3) begin
      bad++; $display("FAIL rst_mid_head got=(%0d,%0d) len=%0d exp=(10,5) len=3", head_x, head_y, body_len); end
    total++; if ({step, hit_wall, hit_body} !== 3'b000 || object !== 2'b00) begin
      bad++; $display("FAIL rst_mid_outs got=%b obj=%b exp=000 obj=00", {step, hit_wall, hit_body}, object); end
  endtask

  initial begin
    test_reset();
    test_object();
    test_step();
    test_grow();
    test_turn();
    test_body_hit();
    test_wall();
    test_rst_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
